// File: rtl/stream_in_matrix_ping_pong_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : stream_matrix_pkg
//  Description: Helpers shared by the matrix stream-out and stream-in blocks.
//               - cnt_w   : counter width for an index range of n values
//               - idx_row : row of row-major element k in a matrix of C columns
//               - idx_col : column of row-major element k
//               - bank_sel_e : ping-pong bank identifier
//  Revision   : 1.0 - initial release
// ============================================================================
package stream_matrix_pkg;

  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_sel_e;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int idx_row(input int k, input int cols);
    return k / cols;
  endfunction

  function automatic int idx_col(input int k, input int cols);
    return k % cols;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_in_matrix_ping_pong_if.sv
`default_nettype none
// ============================================================================
//  Interface  : stream_in_matrix_ping_pong_if
//  Description: Serial element link into the matrix collector plus the
//               completed-matrix outputs.
//    in_valid  : in_data carries one element this cycle
//    in_data   : BITS-wide element, row-major order
//    in_first  : with in_valid, marks element 0 of a matrix
//    out_valid : 1-cycle pulse, c holds a newly completed matrix
//    c         : completed R x C matrix, c[row][col]
//    frame_err : 1-cycle pulse, in_first arrived mid-frame
//  Modports   : master = element source / matrix consumer, slave = collector
//  Revision   : 1.0 - initial release
// ============================================================================
interface stream_in_matrix_ping_pong_if #(
  parameter int BITS = 8,
  parameter int R    = 3,
  parameter int C    = 3
);

  logic                             in_valid;
  logic [BITS-1:0]                  in_data;
  logic                             in_first;
  logic                             out_valid;
  logic [R-1:0][C-1:0][BITS-1:0]    c;
  logic                             frame_err;

  modport master (
    output in_valid,
    output in_data,
    output in_first,
    input  out_valid,
    input  c,
    input  frame_err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_first,
    output out_valid,
    output c,
    output frame_err
  );

endinterface
`default_nettype wire

// File: rtl/stream_in_matrix_ping_pong_bank.sv
`default_nettype none
// ============================================================================
//  Module     : matrix_bank_reg
//  Description: One R x C bank of BITS-wide element registers. A single
//               element addressed by (row, col) is written when wr_en is high.
//    clk    : clock
//    reset  : asynchronous active-high reset, clears every element
//    wr_en  : write enable
//    row    : row index of the element to write
//    col    : column index of the element to write
//    data   : element value
//    mat    : full matrix contents, mat[row][col]
//  Revision   : 1.0 - initial release
// ============================================================================
module matrix_bank_reg
  import stream_matrix_pkg::*;
#(
  parameter int BITS = 8,
  parameter int R    = 3,
  parameter int C    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [cnt_w(R)-1:0]           row,
  input  logic [cnt_w(C)-1:0]           col,
  input  logic [BITS-1:0]               data,
  output logic [R-1:0][C-1:0][BITS-1:0] mat
);

  localparam int c_RW = cnt_w(R);
  localparam int c_CW = cnt_w(C);

  logic [R-1:0][C-1:0][BITS-1:0] r_mat;

  // Per-element decode rather than a direct variable index, so that
  // single-row / single-column shapes need no special casing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mat <= '0;
    end else begin
      for (int i = 0; i < R; i++) begin
        for (int j = 0; j < C; j++) begin
          if (wr_en && (row == c_RW'(i)) && (col == c_CW'(j))) begin
            r_mat[i][j] <= data;
          end
        end
      end
    end
  end

  assign mat = r_mat;

endmodule
`default_nettype wire

// File: rtl/stream_in_matrix_ping_pong.sv
`default_nettype none
// ============================================================================
//  Module     : stream_in_matrix_ping_pong
//  Description: Serial-to-matrix collector with ping-pong storage. Row-major
//               elements fill the write bank; when the last element lands the
//               banks swap and the completed matrix is presented on c with a
//               1-cycle out_valid pulse. The read bank stays stable while the
//               next matrix fills the other bank.
//    clk   : clock, all state on posedge
//    reset : asynchronous active-high reset
//    bus   : slave side of stream_in_matrix_ping_pong_if
//            (in_valid, in_data, in_first -> out_valid, c, frame_err)
//  Revision   : 1.0 - initial release
// ============================================================================
module stream_in_matrix_ping_pong
  import stream_matrix_pkg::*;
#(
  parameter int BITS = 8,
  parameter int R    = 3,
  parameter int C    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  stream_in_matrix_ping_pong_if.slave   bus
);

  localparam int c_ELEMENTS = R * C;
  localparam int c_CNT_W    = cnt_w(c_ELEMENTS);
  localparam int c_ROW_W    = cnt_w(R);
  localparam int c_COL_W    = cnt_w(C);

  logic [c_CNT_W-1:0]            r_count;
  bank_sel_e                     r_wr_bank;
  logic                          r_out_valid;
  logic                          r_frame_err;

  logic [c_CNT_W-1:0]            w_k;
  logic                          w_last;
  logic [c_ROW_W-1:0]            w_row;
  logic [c_COL_W-1:0]            w_col;
  logic                          w_wr_en0;
  logic                          w_wr_en1;
  logic [R-1:0][C-1:0][BITS-1:0] w_bank0;
  logic [R-1:0][C-1:0][BITS-1:0] w_bank1;

  // in_first always restarts at element 0; a mid-frame restart simply
  // overwrites the write bank from the top, discarding the partial frame.
  assign w_k    = bus.in_first ? '0 : r_count;
  assign w_last = (w_k == c_CNT_W'(c_ELEMENTS - 1));
  assign w_row  = c_ROW_W'(idx_row(int'(w_k), C));
  assign w_col  = c_COL_W'(idx_col(int'(w_k), C));

  assign w_wr_en0 = bus.in_valid && (r_wr_bank == BANK_0);
  assign w_wr_en1 = bus.in_valid && (r_wr_bank == BANK_1);

  matrix_bank_reg #(
    .BITS (BITS),
    .R    (R),
    .C    (C)
  ) u_bank0 (
    .clk   (clk),
    .reset (reset),
    .wr_en (w_wr_en0),
    .row   (w_row),
    .col   (w_col),
    .data  (bus.in_data),
    .mat   (w_bank0)
  );

  matrix_bank_reg #(
    .BITS (BITS),
    .R    (R),
    .C    (C)
  ) u_bank1 (
    .clk   (clk),
    .reset (reset),
    .wr_en (w_wr_en1),
    .row   (w_row),
    .col   (w_col),
    .data  (bus.in_data),
    .mat   (w_bank1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_wr_bank   <= BANK_0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid && w_last;
      r_frame_err <= bus.in_valid && bus.in_first && (r_count != '0);
      if (bus.in_valid) begin
        if (w_last) begin
          r_count   <= '0;
          r_wr_bank <= (r_wr_bank == BANK_0) ? BANK_1 : BANK_0;
        end else begin
          r_count   <= w_k + c_CNT_W'(1);
        end
      end
    end
  end

  // The read bank is always the one not being written. The bank swap and
  // the out_valid pulse are registered on the same edge, so c and
  // out_valid change together.
  assign bus.c         = (r_wr_bank == BANK_0) ? w_bank1 : w_bank0;
  assign bus.out_valid = r_out_valid;
  assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_stream_in_matrix_ping_pong.sv
`default_nettype none
// ============================================================================
//  Module     : tb_stream_in_matrix_ping_pong
//  Description: Self-checking bench for stream_in_matrix_ping_pong.
//               3x3/8-bit instance driven from a vector table plus directed
//               sequences; 2x4/16-bit instance with random matrices and a
//               scoreboard; 1x1 instance for the single-element frame case.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_stream_in_matrix_ping_pong;

  typedef logic [71:0] mat_t;

  typedef struct {
    logic       v;
    logic       f;
    logic [7:0] d;
    logic       ev;
    logic       ee;
    mat_t       ec;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  stream_in_matrix_ping_pong_if #(.BITS(8),  .R(3), .C(3)) bus_a ();
  stream_in_matrix_ping_pong_if #(.BITS(16), .R(2), .C(4)) bus_b ();
  stream_in_matrix_ping_pong_if #(.BITS(8),  .R(1), .C(1)) bus_c ();

  stream_in_matrix_ping_pong #(.BITS(8),  .R(3), .C(3)) dut_a (
    .clk (clk), .reset (reset), .bus (bus_a)
  );
  stream_in_matrix_ping_pong #(.BITS(16), .R(2), .C(4)) dut_b (
    .clk (clk), .reset (reset), .bus (bus_b)
  );
  stream_in_matrix_ping_pong #(.BITS(8),  .R(1), .C(1)) dut_c (
    .clk (clk), .reset (reset), .bus (bus_c)
  );

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic mat_t seq_mat(input logic [7:0] start);
    mat_t m;
    for (int k = 0; k < 9; k++) m[k*8 +: 8] = start + 8'(k);
    return m;
  endfunction

  function automatic void add(input logic v, input logic f, input logic [7:0] d,
                              input logic ev, input logic ee, input mat_t ec);
    vec_t t;
    t.v = v; t.f = f; t.d = d; t.ev = ev; t.ee = ee; t.ec = ec;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step_a(input logic v, input logic f, input logic [7:0] d);
    bus_a.in_valid = v; bus_a.in_first = f; bus_a.in_data = d;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic v, input logic f, input logic [15:0] d, input logic exp_ov);
    bus_b.in_valid = v; bus_b.in_first = f; bus_b.in_data = d;
    @(posedge clk); #1;
    check("T6 out_valid", 128'(bus_b.out_valid), 128'(exp_ov));
    check("T6 frame_err", 128'(bus_b.frame_err), 128'(0));
  endtask

  task automatic step_c(input logic v, input logic f, input logic [7:0] d,
                        input logic exp_ov, input logic [7:0] exp_c);
    bus_c.in_valid = v; bus_c.in_first = f; bus_c.in_data = d;
    @(posedge clk); #1;
    check("1x1 out_valid", 128'(bus_c.out_valid), 128'(exp_ov));
    check("1x1 frame_err", 128'(bus_c.frame_err), 128'(0));
    check("1x1 c", 128'(bus_c.c), 128'(exp_c));
  endtask

  initial begin
    logic [127:0] tx;
    logic [15:0]  d16;
    mat_t         s1, s11, sa0;

    s1  = seq_mat(8'h01);
    s11 = seq_mat(8'h11);
    sa0 = seq_mat(8'hA0);

    // T1: 1..9 contiguous, in_first on element 0
    for (int k = 0; k < 9; k++)
      add(1'b1, k == 0, 8'(k + 1), k == 8, 1'b0, (k == 8) ? s1 : '0);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, s1);
    // T3: 0x11..0x19, valid every third cycle
    for (int k = 0; k < 9; k++) begin
      add(1'b1, k == 0, 8'(8'h11 + k), k == 8, 1'b0, (k == 8) ? s11 : s1);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, (k == 8) ? s11 : s1);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, (k == 8) ? s11 : s1);
    end
    // T4: partial 1..5, restart with in_first on 0xA0, then 0xA1..0xA8
    for (int k = 0; k < 5; k++)
      add(1'b1, k == 0, 8'(k + 1), 1'b0, 1'b0, s11);
    add(1'b1, 1'b1, 8'hA0, 1'b0, 1'b1, s11);
    for (int k = 1; k < 9; k++)
      add(1'b1, 1'b0, 8'(8'hA0 + k), k == 8, 1'b0, (k == 8) ? sa0 : s11);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, sa0);

    bus_a.in_valid = 1'b0; bus_a.in_first = 1'b0; bus_a.in_data = '0;
    bus_b.in_valid = 1'b0; bus_b.in_first = 1'b0; bus_b.in_data = '0;
    bus_c.in_valid = 1'b0; bus_c.in_first = 1'b0; bus_c.in_data = '0;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    check("reset out_valid", 128'(bus_a.out_valid), 128'(0));
    check("reset frame_err", 128'(bus_a.frame_err), 128'(0));
    check("reset c", 128'(bus_a.c), 128'(0));
    check("reset 2x4 c", 128'(bus_b.c), 128'(0));

    // Table-driven T1, T3, T4
    foreach (vecs[i]) begin
      step_a(vecs[i].v, vecs[i].f, vecs[i].d);
      check($sformatf("vec%0d out_valid", i), 128'(bus_a.out_valid), 128'(vecs[i].ev));
      check($sformatf("vec%0d frame_err", i), 128'(bus_a.frame_err), 128'(vecs[i].ee));
      check($sformatf("vec%0d c", i), 128'(bus_a.c), 128'(vecs[i].ec));
    end

    // T2: 18 contiguous elements 1..18 -> pulses on the 9th and 18th
    for (int i = 1; i <= 18; i++) begin
      step_a(1'b1, i == 1, 8'(i));
      check($sformatf("T2 out_valid %0d", i), 128'(bus_a.out_valid), 128'(i == 9 || i == 18));
      check($sformatf("T2 frame_err %0d", i), 128'(bus_a.frame_err), 128'(0));
      check($sformatf("T2 c %0d", i), 128'(bus_a.c),
            128'((i < 9) ? sa0 : (i < 18) ? s1 : seq_mat(8'h0A)));
    end
    step_a(1'b0, 1'b0, 8'h00);
    check("T2 idle out_valid", 128'(bus_a.out_valid), 128'(0));

    // T6: 2x4 / 16-bit, random matrices with random gaps
    for (int m = 0; m < 30; m++) begin
      tx = '0;
      for (int e = 0; e < 8; e++) begin
        if ($urandom_range(0, 3) == 0) step_b(1'b0, 1'b0, 16'h0000, 1'b0);
        d16 = 16'($urandom);
        tx[e*16 +: 16] = d16;
        step_b(1'b1, e == 0, d16, e == 7);
      end
      check($sformatf("T6 c matrix %0d", m), 128'(bus_b.c), tx);
    end
    step_b(1'b0, 1'b0, 16'h0000, 1'b0);
    check("T6 c held", 128'(bus_b.c), tx);

    // 1x1: every valid completes a frame, in_first is never an error
    step_c(1'b1, 1'b0, 8'h05, 1'b1, 8'h05);
    step_c(1'b1, 1'b1, 8'h06, 1'b1, 8'h06);
    step_c(1'b1, 1'b0, 8'h07, 1'b1, 8'h07);
    step_c(1'b0, 1'b0, 8'h00, 1'b0, 8'h07);

    // T5: partial frame, asynchronous reset, then a fresh frame without in_first
    for (int i = 0; i < 4; i++) step_a(1'b1, i == 0, 8'(8'h21 + i));
    bus_a.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("T5 async c", 128'(bus_a.c), 128'(0));
    check("T5 async out_valid", 128'(bus_a.out_valid), 128'(0));
    check("T5 async frame_err", 128'(bus_a.frame_err), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step_a(1'b1, 1'b0, 8'(8'h31 + i));
      check($sformatf("T5 out_valid %0d", i), 128'(bus_a.out_valid), 128'(i == 8));
      check($sformatf("T5 frame_err %0d", i), 128'(bus_a.frame_err), 128'(0));
      check($sformatf("T5 c %0d", i), 128'(bus_a.c), 128'((i == 8) ? seq_mat(8'h31) : '0));
    end
    step_a(1'b0, 1'b0, 8'h00);
    check("T5 idle out_valid", 128'(bus_a.out_valid), 128'(0));
    check("T5 idle c", 128'(bus_a.c), 128'(seq_mat(8'h31)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
